wb_cmd_arb: RTL
===============

Name: wb_cmd_arb

Overview:
Two-requester command arbiter and sequencer placed upstream of the config/routing macro. It shares the single wb_cmd_* command path between requester 0 (the Wishbone slave front end) and requester 1 (the on-chip test/BIST sequencer). It runs one command at a time: arbitrate, issue a one-cycle command, wait for the read ack, then return the response to the requester that owns the command.

Parameters:
TMO_CYC, 256, number of WAIT cycles without rd_ack before a read times out (used only with the optional feature); legal range 2..65535.
TMO_DATA, 32'hDEADDEAD, read data returned when a read times out.

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
r0_req_val  in  1  requester 0 command valid
r0_req_adr  in  32  requester 0 address
r0_req_we  in  1  requester 0 write enable
r0_req_sel  in  4  requester 0 byte selects
r0_req_dat  in  32  requester 0 write data
r0_req_rdy  out  1  requester 0 command accepted this cycle
r0_rsp_val  out  1  requester 0 response valid, one-cycle pulse
r0_rsp_dat  out  32  requester 0 response data
r0_rsp_err  out  1  requester 0 timeout error flag
r1_*  same nine signals as r0_*  requester 1
cmd_val  out  1  command valid toward the routing macro
cmd_adr  out  32  command address
cmd_we  out  1  command write enable
cmd_sel  out  4  command byte selects
cmd_dat  out  32  command write data
rd_ack  in  1  read acknowledge from the routed macro
rd_dat  in  32  read data from the routed macro
busy  out  1  high whenever the FSM is not in IDLE

Behaviour:
- FSM states: IDLE, ISSUE, WAIT, RESP. Reset puts the FSM in IDLE.
- Reset values: every output is 0, the command holding registers are 0, and last_q = 1 (so r0 wins the first contention).
- IDLE:
  - rX_req_rdy is driven combinationally, and only to the arbitration winner.
  - One requester valid: it wins.
  - Both valid: the requester other than last_q wins.
  - Accept = val & rdy. On accept, register adr/we/sel/dat and the owner id, set last_q = owner, and go to ISSUE.
  - rdy is never asserted outside IDLE.
- ISSUE:
  - cmd_val = 1 for exactly one cycle; cmd_* are driven from the registers.
  - cmd_* are 0 in every state other than ISSUE.
  - Write: go to RESP with rsp_dat = 0. No ack is expected.
  - Read with rd_ack in the same cycle: capture rd_dat and go to RESP.
  - Read without rd_ack: go to WAIT.
- WAIT: hold until rd_ack, then capture rd_dat and go to RESP.
- RESP: the owner's rsp_val = 1 for one cycle with the registered dat/err; the other requester's rsp_val stays 0. Next state is IDLE.
- Latency, with accept in cycle N:
  - cmd_val in cycle N+1.
  - Write response in cycle N+2.
  - Read with ack in cycle N+1+k: response in cycle N+2+k (k ≥ 0).
  - Minimum spacing between accepts is 3 cycles.
- rd_ack in IDLE, RESP or on a write ISSUE: ignored; no state change.
- rsp_dat/rsp_err hold their value outside RESP, but are valid only while rsp_val = 1.
- Reset mid-operation: the FSM returns to IDLE with no response and no further cmd_val; the requester must reissue.
- Requesters must keep req_* stable until accepted; the arbiter does not sample them before accept.

Optional Feature:
Macro WB_CMD_ARB_TIMEOUT_EN.
- Defined:
  - A 16-bit counter clears on entry to WAIT and increments each WAIT cycle.
  - If the counter reaches TMO_CYC-1 without rd_ack, go to RESP with rsp_dat = TMO_DATA and rsp_err = 1.
  - rd_ack in the same cycle as the timeout wins: normal data, err = 0.
- Undefined: no counter is built, WAIT lasts indefinitely, and rsp_err is tied to 0.

Decomposition:
- The shared package holds:
  - the state encodings (IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, RESP = 2'd3);
  - the requester id constants (REQ0 = 1'b0, REQ1 = 1'b1);
  - the TMO_CYC/TMO_DATA defaults.
- One sub-module, wb_cmd_arb_rr: the combinational 2-way round-robin grant, with inputs req[1:0] and last and output gnt[1:0] (one-hot or zero).

Test Plan:
- Reset, then r0 write adr 0x00000000, dat 0x12345678 → cmd_val pulses 1 cycle after accept with the matching fields; r0_rsp_val 2 cycles after accept; r1_rsp_val stays 0.
- r1 read adr 0x00010004, rd_ack with rd_dat 0xCAFEF00D 3 cycles after cmd_val → r1_rsp_dat = 0xCAFEF00D, err = 0, 4 cycles after cmd_val.
- r0 and r1 both held valid for 4 commands → grants alternate r0, r1, r0, r1, with accepts 3 cycles apart.
- rd_ack pulsed in IDLE, and a read ack arriving in the same cycle as ISSUE → no state change in the first case; a response 1 cycle after ISSUE in the second.
- With WB_CMD_ARB_TIMEOUT_EN and TMO_CYC = 8, a read that is never acked → rsp_val with dat 0xDEADDEAD and err = 1; ack arriving in the exact timeout cycle → real data with err = 0.
- rst asserted in WAIT → busy = 0, no rsp_val, and no cmd_val on the next cycle; a fresh r0 read afterwards completes normally.

Source files
------------

// File: rtl/wb_cmd_arb_pkg.sv
// Shared definitions for the wb_cmd_arb command arbiter/sequencer.
// Holds the FSM state encoding, requester ids, parameter defaults and
// the command record that is captured at accept time.
package wb_cmd_arb_pkg;

    // Sequencer states: one command is in flight from ISSUE through RESP
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    // Requester ids, also used as the round-robin "last owner" value
    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

    // Read timeout defaults
    localparam int unsigned TMO_CYC_DEFAULT  = 256;
    localparam logic [31:0] TMO_DATA_DEFAULT = 32'hDEADDEAD;

    // Everything the arbiter has to remember about an accepted command
    typedef struct packed {
        logic [31:0] adr;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] dat;
    } cmd_t;

    // Bundles one requester's loose request fields into a command record
    function automatic cmd_t make_cmd(
        input logic [31:0] adr,
        input logic        we,
        input logic [3:0]  sel,
        input logic [31:0] dat
    );
        cmd_t c;
        c.adr = adr;
        c.we  = we;
        c.sel = sel;
        c.dat = dat;
        return c;
    endfunction

endpackage

// File: rtl/wb_cmd_arb_rr.sv
// Two-way round-robin grant for wb_cmd_arb.
// Purely combinational: a lone requester always wins; under contention
// the requester that did not own the previous command wins.
module wb_cmd_arb_rr
    import wb_cmd_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    // Grant is one-hot for the winner, or zero when nobody is asking
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (last == REQ1) ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/wb_cmd_arb.sv
// Two-requester command arbiter and sequencer in front of the
// config/routing macro. Requester 0 is the Wishbone slave front end,
// requester 1 the test/BIST sequencer. One command is in flight at a time:
// arbitrate in IDLE, pulse the command in ISSUE, wait for the read ack in
// WAIT, then hand the response back to the owner in RESP.
//
// Optional read timeout: define WB_CMD_ARB_TIMEOUT_EN to build a 16-bit
// WAIT cycle counter that forces a TMO_DATA/err response after TMO_CYC
// cycles without rd_ack. Without it WAIT lasts until rd_ack and the
// rsp_err outputs are tied low.
module wb_cmd_arb
    import wb_cmd_arb_pkg::*;
#(
    parameter int unsigned TMO_CYC  = TMO_CYC_DEFAULT,
    parameter logic [31:0] TMO_DATA = TMO_DATA_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        r0_req_val,
    input  logic [31:0] r0_req_adr,
    input  logic        r0_req_we,
    input  logic [3:0]  r0_req_sel,
    input  logic [31:0] r0_req_dat,
    output logic        r0_req_rdy,
    output logic        r0_rsp_val,
    output logic [31:0] r0_rsp_dat,
    output logic        r0_rsp_err,

    input  logic        r1_req_val,
    input  logic [31:0] r1_req_adr,
    input  logic        r1_req_we,
    input  logic [3:0]  r1_req_sel,
    input  logic [31:0] r1_req_dat,
    output logic        r1_req_rdy,
    output logic        r1_rsp_val,
    output logic [31:0] r1_rsp_dat,
    output logic        r1_rsp_err,

    output logic        cmd_val,
    output logic [31:0] cmd_adr,
    output logic        cmd_we,
    output logic [3:0]  cmd_sel,
    output logic [31:0] cmd_dat,
    input  logic        rd_ack,
    input  logic [31:0] rd_dat,
    output logic        busy
);

    // A TMO_CYC outside 2..65535 cannot be represented by the WAIT counter
    if (TMO_CYC < 2 || TMO_CYC > 65535) begin : g_tmo_range_bad
        $error("wb_cmd_arb: TMO_CYC must lie in 2..65535");
    end

    state_t      state_q, state_d;
    cmd_t        cmd_q, cmd_d;
    logic        owner_q, owner_d;
    logic        last_q, last_d;
    logic [31:0] rsp_dat_q, rsp_dat_d;

    logic [1:0]  gnt;
    logic        accept;
    logic        read_done;
    logic        tmo_hit;
    cmd_t        req0_cmd;
    cmd_t        req1_cmd;

`ifdef WB_CMD_ARB_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(TMO_CYC - 1);

    logic [15:0] tmo_cnt_q, tmo_cnt_d;
    logic        rsp_err_q, rsp_err_d;
`endif

    assign req0_cmd = make_cmd(r0_req_adr, r0_req_we, r0_req_sel, r0_req_dat);
    assign req1_cmd = make_cmd(r1_req_adr, r1_req_we, r1_req_sel, r1_req_dat);

    wb_cmd_arb_rr u_rr (
        .req  ({r1_req_val, r0_req_val}),
        .last (last_q),
        .gnt  (gnt)
    );

    // The grant only turns into a handshake while the sequencer is idle
    assign accept = (state_q == IDLE) && (gnt != 2'b00);

    // A read completes when the ack lands in ISSUE (zero wait) or in WAIT
    assign read_done = rd_ack && !cmd_q.we && ((state_q == ISSUE) || (state_q == WAIT));

`ifdef WB_CMD_ARB_TIMEOUT_EN
    // Last permitted WAIT cycle reached with no ack in sight
    assign tmo_hit = (state_q == WAIT) && (tmo_cnt_q == TMO_LAST) && !rd_ack;
`else
    assign tmo_hit = 1'b0;
`endif

    // State register; reset abandons any command in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: one command walks IDLE -> ISSUE -> [WAIT] -> RESP
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (cmd_q.we || rd_ack) begin
                    state_d = RESP;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (rd_ack || tmo_hit) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Datapath next values: capture the winner's command and the response
    always_comb begin
        cmd_d     = cmd_q;
        owner_d   = owner_q;
        last_d    = last_q;
        rsp_dat_d = rsp_dat_q;
`ifdef WB_CMD_ARB_TIMEOUT_EN
        rsp_err_d = rsp_err_q;
`endif
        if (accept) begin
            owner_d = gnt[1] ? REQ1 : REQ0;
            last_d  = owner_d;
            cmd_d   = (owner_d == REQ1) ? req1_cmd : req0_cmd;
        end
        if ((state_q == ISSUE) && cmd_q.we) begin
            rsp_dat_d = '0;
`ifdef WB_CMD_ARB_TIMEOUT_EN
            rsp_err_d = 1'b0;
`endif
        end else if (read_done) begin
            rsp_dat_d = rd_dat;
`ifdef WB_CMD_ARB_TIMEOUT_EN
            rsp_err_d = 1'b0;
`endif
        end else if (tmo_hit) begin
            rsp_dat_d = TMO_DATA;
`ifdef WB_CMD_ARB_TIMEOUT_EN
            rsp_err_d = 1'b1;
`endif
        end
    end

    // Datapath registers; last owner resets to REQ1 so r0 wins first contention
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_q     <= '0;
            owner_q   <= REQ0;
            last_q    <= REQ1;
            rsp_dat_q <= '0;
        end else begin
            cmd_q     <= cmd_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            rsp_dat_q <= rsp_dat_d;
        end
    end

`ifdef WB_CMD_ARB_TIMEOUT_EN
    // WAIT counter restarts from zero every time WAIT is entered
    always_comb begin
        tmo_cnt_d = '0;
        if (state_q == WAIT) begin
            tmo_cnt_d = tmo_cnt_q + 16'd1;
        end
    end

    // Timeout counter and error flag registers
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt_q <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            rsp_err_q <= rsp_err_d;
        end
    end
`endif

    // Outputs decoded from the state; cmd_* are forced to zero outside ISSUE
    always_comb begin
        r0_req_rdy = (state_q == IDLE) && gnt[0];
        r1_req_rdy = (state_q == IDLE) && gnt[1];

        cmd_val = (state_q == ISSUE);
        cmd_adr = '0;
        cmd_we  = 1'b0;
        cmd_sel = '0;
        cmd_dat = '0;
        if (state_q == ISSUE) begin
            cmd_adr = cmd_q.adr;
            cmd_we  = cmd_q.we;
            cmd_sel = cmd_q.sel;
            cmd_dat = cmd_q.dat;
        end

        r0_rsp_val = (state_q == RESP) && (owner_q == REQ0);
        r1_rsp_val = (state_q == RESP) && (owner_q == REQ1);
        r0_rsp_dat = rsp_dat_q;
        r1_rsp_dat = rsp_dat_q;
`ifdef WB_CMD_ARB_TIMEOUT_EN
        r0_rsp_err = rsp_err_q;
        r1_rsp_err = rsp_err_q;
`else
        r0_rsp_err = 1'b0;
        r1_rsp_err = 1'b0;
`endif

        busy = (state_q != IDLE);
    end

endmodule
